// File: rtl/bubble_sort_gen.sv
// In-place bubble-sort engine for a single-port synchronous RAM with one-cycle
// read latency. Supports ascending/descending order, early termination when a
// pass makes no swaps, length range checking and swap/pass statistics.
module bubble_sort_gen #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    output logic              ready,
    input  logic              descend,
    input  logic [LEN_W-1:0]  length,
    input  logic [DATA_W-1:0] rdata,
    output logic [ADDR_W-1:0] address,
    output logic              wren,
    output logic [DATA_W-1:0] wdata,
    output logic              done,
    output logic              err,
    output logic [CNT_W-1:0]  swap_count,
    output logic [CNT_W-1:0]  pass_count
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] RD_A   = 3'd1;
    localparam logic [2:0] RD_B   = 3'd2;
    localparam logic [2:0] CMP    = 3'd3;
    localparam logic [2:0] WR_A   = 3'd4;
    localparam logic [2:0] WR_B   = 3'd5;
    localparam logic [2:0] NEXT   = 3'd6;
    localparam logic [2:0] FINISH = 3'd7;

    // Wide enough to hold both the length and DEPTH without truncation.
    localparam int EXT_W = (LEN_W > ADDR_W) ? LEN_W + 1 : ADDR_W + 1;
    localparam logic [EXT_W-1:0] DEPTH_E = EXT_W'(1) << ADDR_W;

    logic [2:0]        state;
    logic [LEN_W-1:0]  i;
    logic [LEN_W-1:0]  limit;
    logic [LEN_W-1:0]  i_nxt;
    logic              desc_q;
    logic              pass_swapped;
    logic              do_swap;
    logic              len_big;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;

    // Counters hold at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign i_nxt   = i + LEN_W'(1);
    assign len_big = EXT_W'(length) > DEPTH_E;
    // In CMP, rdata carries mem[i+1]; unsigned compare against the latched mem[i].
    assign do_swap = desc_q ? (a_q < rdata) : (a_q > rdata);

    // Control FSM, index/limit bookkeeping and statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            i            <= '0;
            limit        <= '0;
            desc_q       <= 1'b0;
            pass_swapped <= 1'b0;
            err          <= 1'b0;
            swap_count   <= '0;
            pass_count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        desc_q       <= descend;
                        err          <= 1'b0;
                        swap_count   <= '0;
                        pass_count   <= '0;
                        limit        <= length - LEN_W'(1);
                        i            <= '0;
                        pass_swapped <= 1'b0;
                        if (len_big) begin
                            err   <= 1'b1;
                            state <= FINISH;
                        end else if (length < LEN_W'(2)) begin
                            state <= FINISH;
                        end else begin
                            // First pass begins immediately.
                            pass_count <= CNT_W'(1);
                            state      <= RD_A;
                        end
                    end
                end
                RD_A: state <= RD_B;
                RD_B: state <= CMP;
                CMP: begin
                    if (do_swap) begin
                        swap_count <= sat_inc(swap_count);
                        state      <= WR_A;
                    end else begin
                        state <= NEXT;
                    end
                end
                WR_A: state <= WR_B;
                WR_B: begin
                    pass_swapped <= 1'b1;
                    state        <= NEXT;
                end
                NEXT: begin
                    if (i_nxt < limit) begin
                        i     <= i_nxt;
                        state <= RD_A;
                    end else begin
                        limit        <= limit - LEN_W'(1);
                        i            <= '0;
                        pass_swapped <= 1'b0;
                        // A clean pass or a shrunk-to-zero window means sorted.
                        if (!pass_swapped || limit == LEN_W'(1)) begin
                            state <= FINISH;
                        end else begin
                            pass_count <= sat_inc(pass_count);
                            state      <= RD_A;
                        end
                    end
                end
                FINISH: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Element holding registers; their contents are don't-care outside a compare.
    always_ff @(posedge clk) begin
        if (state == RD_B) a_q <= rdata;
        if (state == CMP)  b_q <= rdata;
    end

    // RAM interface and status decoded purely from registered state and index.
    always_comb begin
        address = '0;
        wren    = 1'b0;
        wdata   = '0;
        case (state)
            RD_A: address = i[ADDR_W-1:0];
            RD_B: address = i_nxt[ADDR_W-1:0];
            WR_A: begin
                address = i[ADDR_W-1:0];
                wren    = 1'b1;
                wdata   = b_q;
            end
            WR_B: begin
                address = i_nxt[ADDR_W-1:0];
                wren    = 1'b1;
                wdata   = a_q;
            end
            default: ;
        endcase
    end

    assign ready = (state == IDLE);
    assign done  = (state == FINISH);

endmodule
